// File: rtl/bch_axil_pkg.sv
// Shared constants for the BCH core AXI4-Lite register block: register map,
// response codes and the read/write channel state encodings.
package bch_axil_pkg;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_STATUS   = 5'h04;
    localparam logic [4:0] OFF_DATA_IN  = 5'h08;
    localparam logic [4:0] OFF_DATA_OUT = 5'h0C;
    localparam logic [4:0] OFF_LED      = 5'h10;
    localparam logic [4:0] OFF_ID       = 5'h14;

    localparam logic [31:0] ID_VALUE = 32'hBC40_0001;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Byte-lane merge of a write into an existing 32-bit register value.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_bch_regs.sv
// AXI4-Lite control/status register block sitting in front of an external BCH core;
// independent write (AW/W/B) and read (AR/R) engines sharing one register set.
module axil_bch_regs
    import bch_axil_pkg::*;
#(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic [2:0]        s_axil_awprot,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    input  logic [DATA_W-1:0] s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    output logic [1:0]        s_axil_bresp,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic [2:0]        s_axil_arprot,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [DATA_W-1:0] s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              core_start,
    output logic [DATA_W-1:0] core_data,
    input  logic              core_busy,
    input  logic              core_done,
    input  logic              core_err,
    input  logic [DATA_W-1:0] core_result,
    output logic [7:0]        LED
);

    logic              active;
    wr_state_t         w_state;
    rd_state_t         r_state;
    logic              aw_done, w_done;
    logic [4:0]        aw_off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q;
    logic [DATA_W-1:0] data_in_q, data_out_q, rdata_q;
    logic [7:0]        led_q;
    logic              done_q, err_q, ign_q, start_q;
    logic [1:0]        rresp_q;

    logic              aw_hs, w_hs, ar_hs, wr_fire, wr_ok;
    logic [4:0]        wr_off, rd_off;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [3:0]        wr_strb;
    logic [1:0]        rd_resp;
    logic              ctrl_wr, start_go, start_skip, clear_req;

    logic unused_bits;
    assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[ADDR_W-1:5], s_axil_awaddr[1:0],
                           s_axil_araddr[ADDR_W-1:5], s_axil_araddr[1:0]};

    // Readies stay low through reset and rise on the first edge after release.
    assign s_axil_awready = active && (w_state == W_IDLE) && !aw_done;
    assign s_axil_wready  = active && (w_state == W_IDLE) && !w_done;
    assign s_axil_arready = active && (r_state == R_IDLE);
    assign s_axil_bvalid  = (w_state == W_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = (r_state == R_DATA);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign core_start     = start_q;
    assign core_data      = data_in_q;
    assign LED            = led_q;

    assign aw_hs   = s_axil_awvalid && s_axil_awready;
    assign w_hs    = s_axil_wvalid && s_axil_wready;
    assign ar_hs   = s_axil_arvalid && s_axil_arready;
    assign wr_fire = (aw_done || aw_hs) && (w_done || w_hs);
    assign rd_off  = {s_axil_araddr[4:2], 2'b00};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        wr_off  = aw_done ? aw_off_q : {s_axil_awaddr[4:2], 2'b00};
        wr_data = w_done ? wdata_q : s_axil_wdata;
        wr_strb = w_done ? wstrb_q : s_axil_wstrb;
        wr_ok   = (wr_off == OFF_CTRL) || (wr_off == OFF_DATA_IN) || (wr_off == OFF_LED);
    end

    assign ctrl_wr    = wr_fire && (wr_off == OFF_CTRL) && wr_strb[0];
    assign start_go   = ctrl_wr && wr_data[0] && !core_busy;
    assign start_skip = ctrl_wr && wr_data[0] && core_busy;
    assign clear_req  = ctrl_wr && wr_data[1];

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_off)
            OFF_STATUS:   rd_data = {28'b0, ign_q, err_q, done_q, core_busy};
            OFF_DATA_IN:  rd_data = data_in_q;
            OFF_DATA_OUT: rd_data = data_out_q;
            OFF_LED:      rd_data = {24'b0, led_q};
            OFF_ID:       rd_data = ID_VALUE;
            default:      rd_resp = RESP_SLVERR;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            w_state  <= W_IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            aw_off_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            active <= 1'b1;
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_done  <= 1'b1;
                        aw_off_q <= {s_axil_awaddr[4:2], 2'b00};
                    end
                    if (w_hs) begin
                        w_done  <= 1'b1;
                        wdata_q <= s_axil_wdata;
                        wstrb_q <= s_axil_wstrb;
                    end
                    if (wr_fire) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (s_axil_bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Core handshake and sticky status; a done arriving with a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_in_q  <= '0;
            data_out_q <= '0;
            led_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ign_q      <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            start_q <= start_go;
            if (wr_fire && (wr_off == OFF_DATA_IN))
                data_in_q <= apply_strb(data_in_q, wr_data, wr_strb);
            if (wr_fire && (wr_off == OFF_LED) && wr_strb[0])
                led_q <= wr_data[7:0];
            if (core_done) begin
                data_out_q <= core_result;
                done_q     <= 1'b1;
                err_q      <= core_err;
            end else if (start_go || clear_req) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (start_skip)
                ign_q <= 1'b1;
            else if (clear_req)
                ign_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    rdata_q <= rd_data;
                    rresp_q <= rd_resp;
                    r_state <= R_DATA;
                end
                R_DATA: if (s_axil_rready) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
